// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx transmitter between NUM_REQ requesters. In IDLE, while the
// transmitter is ready, a round-robin search starting at ptr picks a winner.
// The arbiter then latches the winner's byte onto tx_data and pulses tx_start.
// It follows the frame through tx_ready: a low tx_ready means the byte was
// accepted, so grant pulses for the winner; tx_ready returning high ends the
// frame. If tx_ready never drops within START_TIMEOUT cycles, err pulses and
// the arbiter re-arbitrates without granting.
//
// Build option:
//   UART_ARB_FIXED_PRIO_EN  defined: fixed priority, lowest index wins
//                           (ptr stays 0); undefined: round-robin.
//
// Ports:
//   clk       system clock, shared with uart_tx
//   rst_n     asynchronous active-low reset
//   req       per-requester byte-pending flags, held until grant
//   req_data  packed bytes, byte i at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant     one-hot 1-cycle pulse: requester's byte accepted by TX
//   tx_start  1-cycle start pulse to uart_tx
//   tx_data   registered byte to uart_tx, stable through the frame
//   tx_ready  ready line from uart_tx
//   busy      high in every state other than IDLE
//   err       1-cycle pulse: transmitter did not accept the start in time
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned START_TIMEOUT = 15
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_ready,
   output logic                          busy,
   output logic                          err
);

   localparam int unsigned PtrW = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(START_TIMEOUT + 1);
   localparam logic [PtrW-1:0] PtrMax = PtrW'(NUM_REQ - 1);
   localparam logic [CntW-1:0] CntMax = CntW'(START_TIMEOUT);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWaitAcc,
      StWaitDone
   } state_e;

   state_e                state_q, state_d;
   logic [PtrW-1:0]       ptr_q, ptr_d;
   logic [PtrW-1:0]       sel_q, sel_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

   logic [PtrW-1:0]       cand;
   logic [PtrW-1:0]       winner;
   logic                  found;

   // Round-robin search: first set req bit at ptr, ptr+1, ... wrapping.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = PtrW'((32'(ptr_q) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      tx_data_d = tx_data_q;
      tx_start  = 1'b0;
      grant     = '0;
      err       = 1'b0;

      case (state_q)
         StIdle: begin
            if (tx_ready && found) begin
               sel_d     = winner;
               tx_data_d = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
               state_d   = StStart;
            end
         end

         StStart: begin
            tx_start = 1'b1;
            cnt_d    = '0;
            state_d  = StWaitAcc;
         end

         StWaitAcc: begin
            if (!tx_ready) begin
               grant[sel_q] = 1'b1;
               state_d      = StWaitDone;
            end else if (cnt_q >= CntMax) begin
               // Start never taken: drop back and retry; ptr untouched so the
               // same requester normally wins again.
               err     = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StWaitDone: begin
            if (tx_ready) begin
`ifdef UART_ARB_FIXED_PRIO_EN
               ptr_d = '0;
`else
               ptr_d = (sel_q == PtrMax) ? '0 : sel_q + 1'b1;
`endif
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign tx_data = tx_data_q;
   assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with a small uart_tx stand-in: start is
// sampled on a clock edge, ready falls one cycle later, then a 10-bit frame
// (start, 8 data bits LSB first, stop) goes out at one bit per clock.
// stuck forces tx_ready high (start never accepted); init_low holds it low.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  grant;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        busy;
   logic        err;

   int n_vec = 0;
   int n_err = 0;

   // Transmitter stand-in
   logic       stuck    = 1'b0;
   logic       init_low = 1'b0;
   logic       m_ready  = 1'b1;
   logic       pend     = 1'b0;
   logic [7:0] m_data   = '0;
   logic [8:0] sh       = '0;
   int         bcnt     = 0;
   logic       line     = 1'b1;

   assign tx_ready = stuck | (!init_low & m_ready);

   always #5 clk = ~clk;

   uart_tx_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .grant    (grant),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .busy     (busy),
      .err      (err)
   );

   always @(posedge clk) begin
      if (pend) begin
         pend    <= 1'b0;
         m_ready <= 1'b0;
         line    <= 1'b0;
         sh      <= {1'b1, m_data};
         bcnt    <= 9;
      end else if (!m_ready) begin
         if (bcnt != 0) begin
            line <= sh[0];
            sh   <= sh >> 1;
            bcnt <= bcnt - 1;
         end else begin
            m_ready <= 1'b1;
            line    <= 1'b1;
         end
      end else if (tx_start && !stuck && !init_low) begin
         pend   <= 1'b1;
         m_data <= tx_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_byte(input int idx, input logic [7:0] b);
      req_data[idx*8 +: 8] = b;
   endtask

   // Wait for tx_start, then check data, grant timing, the line frame and the
   // return to IDLE. Returns at the negedge of the first IDLE cycle.
   task automatic do_frame(input int idx, input logic [7:0] data, input bit reraise,
                           output int lat);
      int k;
      logic [9:0] bits;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!tx_start && k < 40);
      lat = k;
      check("start_seen", 32'(tx_start), 32'd1);
      check("tx_data", 32'(tx_data), 32'(data));
      @(negedge clk);
      check("start_pulse", 32'(tx_start), 32'd0);
      check("grant_early", 32'(grant), 32'd0);
      @(negedge clk);
      check("grant", 32'(grant), 32'd1 << idx);
      check("err_with_grant", 32'(err), 32'd0);
      req[idx] = 1'b0;
      bits = '0;
      bits[0] = line;
      for (int m = 1; m < 10; m++) begin
         @(negedge clk);
         bits[m] = line;
         if (m == 1) begin
            check("grant_pulse", 32'(grant), 32'd0);
            if (reraise) req[idx] = 1'b1;
         end
      end
      check("line_frame", 32'(bits), 32'({1'b1, data, 1'b0}));
      k = 0;
      while (busy && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("frame_done", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int k;
      bit any_start;

      // Reset values
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_start", 32'(tx_start), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_data", 32'(tx_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: single requester 2, byte A5
      set_byte(2, 8'hA5);
      req = 4'b0100;
      do_frame(2, 8'hA5, 1'b0, lat);
      check("t1_latency", 32'(lat), 32'd1);

      // Reset brings ptr back to 0 before the round-robin run
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 2: all four requesting, re-raised after each grant
      set_byte(0, 8'h10);
      set_byte(1, 8'h21);
      set_byte(2, 8'h32);
      set_byte(3, 8'h43);
      req = 4'b1111;
      do_frame(0, 8'h10, 1'b1, lat);
      do_frame(1, 8'h21, 1'b1, lat);
      do_frame(2, 8'h32, 1'b1, lat);
      do_frame(3, 8'h43, 1'b1, lat);
      do_frame(0, 8'h10, 1'b1, lat);
      req = 4'b0000;
      @(negedge clk);

      // 3: req=1001; round-robin alternates, fixed priority starves 3
      set_byte(0, 8'h0F);
      set_byte(3, 8'hF3);
      req = 4'b1001;
`ifdef UART_ARB_FIXED_PRIO_EN
      do_frame(0, 8'h0F, 1'b1, lat);
      do_frame(0, 8'h0F, 1'b1, lat);
      do_frame(0, 8'h0F, 1'b1, lat);
`else
      do_frame(3, 8'hF3, 1'b1, lat);
      do_frame(0, 8'h0F, 1'b1, lat);
      do_frame(3, 8'hF3, 1'b1, lat);
`endif
      req[0] = 1'b0;
      do_frame(3, 8'hF3, 1'b0, lat);
      req = 4'b0000;
      @(negedge clk);

      // 4: stuck-ready transmitter -> err after START_TIMEOUT+1, then retry
      stuck = 1'b1;
      set_byte(1, 8'hC3);
      req = 4'b0010;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!tx_start && k < 40);
      check("t4_start", 32'(tx_start), 32'd1);
      for (int j = 1; j <= 17; j++) begin
         @(negedge clk);
         check("t4_err", 32'(err), (j == 16) ? 32'd1 : 32'd0);
         check("t4_no_grant", 32'(grant), 32'd0);
         check("t4_no_start", 32'(tx_start), 32'd0);
      end
      @(negedge clk);
      check("t4_retry_start", 32'(tx_start), 32'd1);
      check("t4_retry_data", 32'(tx_data), 32'hC3);
      stuck = 1'b0;
      @(negedge clk);
      check("t4_grant_early", 32'(grant), 32'd0);
      @(negedge clk);
      check("t4_grant", 32'(grant), 32'b0010);
      req = 4'b0000;
      k = 0;
      while (busy && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("t4_done", 32'(busy), 32'd0);

      // 5: reset while in WAIT_DONE, then arbitration restarts at ptr=0
      set_byte(0, 8'h5A);
      req = 4'b0001;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (grant == 4'b0000 && k < 40);
      check("t5_grant", 32'(grant), 32'b0001);
      req = 4'b0000;
      repeat (3) @(negedge clk);
      check("t5_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_start", 32'(tx_start), 32'd0);
      check("t5_grant0", 32'(grant), 32'd0);
      check("t5_data", 32'(tx_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_byte(1, 8'h66);
      set_byte(2, 8'h77);
      req = 4'b0110;
      do_frame(1, 8'h66, 1'b0, lat);
      do_frame(2, 8'h77, 1'b0, lat);
      req = 4'b0000;
      @(negedge clk);

      // 6: transmitter still initialising (ready low) holds off the start
      init_low = 1'b1;
      set_byte(0, 8'h81);
      req = 4'b0001;
      any_start = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (tx_start) any_start = 1'b1;
      end
      check("t6_no_start", 32'(any_start), 32'd0);
      check("t6_idle", 32'(busy), 32'd0);
      init_low = 1'b0;
      do_frame(0, 8'h81, 1'b0, lat);
      check("t6_latency", 32'(lat), 32'd1);
      req = 4'b0000;

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
